// File: rtl/bcd_sched_pkg.sv
// bcd_sched_pkg: shared types and constants for the BCD converter scheduler
package bcd_sched_pkg;
  typedef enum logic {IDLE, RUN} state_t;
  typedef logic [3:0] bcd_digit_t;
  typedef struct packed {
    bcd_digit_t millares;
    bcd_digit_t centenas;
    bcd_digit_t decenas;
    bcd_digit_t unidades;
  } bcd4_t;
  localparam logic [15:0] BCD_MAX = 16'd9999;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter, first request at or after ptr wins
module rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [N_REQ-1:0]         gnt
);
  localparam int PW = $clog2(N_REQ);
  logic [PW-1:0] idx;
  always_comb begin
    gnt = '0;
    idx = '0;
    // scan from the farthest offset down so the nearest requester overwrites
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = PW'((int'(ptr) + i) % N_REQ);
      if (req[idx]) gnt = N_REQ'(1) << idx;
    end
  end
endmodule

// File: rtl/bcd_conv_sched.sv
// bcd_conv_sched: round-robin scheduler sharing one binary-to-BCD converter.
// Define BCD_CLAMP_EN to clamp inputs above 9999 and flag them on rsp_clamp.
module bcd_conv_sched
  import bcd_sched_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 128
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [16*N_REQ-1:0]  req_data,
  output logic [N_REQ-1:0]     req_ready,
  output logic [N_REQ-1:0]     rsp_valid,
  output logic [15:0]          rsp_bcd,
  output logic                 rsp_error,
  output logic                 rsp_clamp,
  output logic                 busy,
  output logic                 conv_rst,
  output logic [15:0]          conv_numero,
  input  logic [3:0]           conv_millares,
  input  logic [3:0]           conv_centenas,
  input  logic [3:0]           conv_decenas,
  input  logic [3:0]           conv_unidades,
  input  logic                 conv_ready
);
  localparam int PW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  state_t            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d, gidx_q, gidx_d, gsel;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [15:0]       numero_q, numero_d, sel_data;
  bcd4_t             bcd_q, bcd_d;
  logic [N_REQ-1:0]  gnt, vld_q, vld_d;
  logic              err_q, err_d, clamp_q, clamp_d, pend_q, pend_d;
  logic              over_in, accept;
  rr_arbiter #(.N_REQ(N_REQ)) u_arb (.req(req_valid), .ptr(ptr_q), .gnt(gnt));
  always_comb begin
    gsel = '0;
    for (int i = 0; i < N_REQ; i++) if (gnt[i]) gsel = PW'(i);
  end
  assign sel_data = req_data[gsel*16 +: 16];
`ifdef BCD_CLAMP_EN
  assign over_in = sel_data > BCD_MAX;
`else
  assign over_in = 1'b0;
`endif
  assign accept      = (state_q == IDLE) && |gnt;
  assign req_ready   = (state_q == IDLE && rst) ? gnt : '0;
  assign rsp_valid   = vld_q;
  assign rsp_bcd     = bcd_q;
  assign rsp_error   = err_q;
  assign rsp_clamp   = clamp_q;
  assign busy        = state_q == RUN;
  assign conv_rst    = state_q == IDLE;
  assign conv_numero = numero_q;
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gidx_d   = gidx_q;
    cnt_d    = cnt_q;
    numero_d = numero_q;
    bcd_d    = bcd_q;
    vld_d    = '0;
    err_d    = err_q;
    clamp_d  = clamp_q;
    pend_d   = pend_q;
    if (state_q == IDLE) begin
      if (accept) begin
        numero_d = over_in ? BCD_MAX : sel_data;
        pend_d   = over_in;
        gidx_d   = gsel;
        ptr_d    = (gsel == PW'(N_REQ - 1)) ? '0 : gsel + 1'b1;
        cnt_d    = '0;
        state_d  = RUN;
      end
    end else begin
      cnt_d = cnt_q + 1'b1;
      // a completing conversion wins over a timeout landing on the same edge
      if (conv_ready || cnt_d == CW'(TIMEOUT_CYCLES)) begin
        bcd_d   = conv_ready ? {conv_millares, conv_centenas, conv_decenas, conv_unidades} : '0;
        err_d   = !conv_ready;
        clamp_d = pend_q;
        vld_d   = N_REQ'(1) << gidx_q;
        state_d = IDLE;
      end
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      gidx_q   <= '0;
      cnt_q    <= '0;
      numero_q <= '0;
      bcd_q    <= '0;
      vld_q    <= '0;
      err_q    <= 1'b0;
      clamp_q  <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gidx_q   <= gidx_d;
      cnt_q    <= cnt_d;
      numero_q <= numero_d;
      bcd_q    <= bcd_d;
      vld_q    <= vld_d;
      err_q    <= err_d;
      clamp_q  <= clamp_d;
      pend_q   <= pend_d;
    end
  end
endmodule

// File: tb/tb_bcd_conv_sched.sv
// tb_bcd_conv_sched: directed bench with a behavioural converter whose latency is m+c+d+6.
module tb_bcd_conv_sched;
  logic        clk, rst;
  logic [3:0]  req_valid, req_ready, rsp_valid;
  logic [63:0] req_data;
  logic [15:0] rsp_bcd, conv_numero, mcnt;
  logic        rsp_error, rsp_clamp, busy, conv_rst, conv_ready, stall;
  logic [3:0]  conv_millares, conv_centenas, conv_decenas, conv_unidades;
  int          lat, checks, errors, n, seen;

  bcd_conv_sched #(.N_REQ(4), .TIMEOUT_CYCLES(128)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_bcd(rsp_bcd),
    .rsp_error(rsp_error), .rsp_clamp(rsp_clamp), .busy(busy),
    .conv_rst(conv_rst), .conv_numero(conv_numero),
    .conv_millares(conv_millares), .conv_centenas(conv_centenas),
    .conv_decenas(conv_decenas), .conv_unidades(conv_unidades),
    .conv_ready(conv_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk) mcnt <= conv_rst ? 16'd0 : mcnt + 16'd1;
  always_comb begin
    lat = int'(conv_numero) / 1000 + (int'(conv_numero) % 1000) / 100 + (int'(conv_numero) % 100) / 10 + 6;
    conv_millares = 4'(int'(conv_numero) / 1000);
    conv_centenas = 4'((int'(conv_numero) % 1000) / 100);
    conv_decenas  = 4'((int'(conv_numero) % 100) / 10);
    conv_unidades = 4'(int'(conv_numero) % 10);
    conv_ready    = !stall && !conv_rst && (int'(mcnt) == lat - 1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_rsp(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (rsp_valid == 4'b0 && cyc < 300);
  endtask

  task automatic run_one(input int idx, input logic [15:0] val, input logic [15:0] eb,
                         input int el, input logic ee, input logic ec);
    int c;
    req_data[idx*16 +: 16] = val;
    req_valid[idx] = 1'b1;
    #1;
    chk("req_ready", 32'(req_ready), 32'(1 << idx));
    @(posedge clk); #1;
    req_valid[idx] = 1'b0;
    chk("busy", 32'(busy), 32'd1);
    wait_rsp(c);
    chk("latency", 32'(c), 32'(el));
    chk("rsp_valid", 32'(rsp_valid), 32'(1 << idx));
    chk("rsp_bcd", 32'(rsp_bcd), 32'(eb));
    chk("rsp_error", 32'(rsp_error), 32'(ee));
    chk("rsp_clamp", 32'(rsp_clamp), 32'(ec));
  endtask

  initial begin
    checks = 0; errors = 0;
    stall = 1'b0; req_valid = '0; req_data = '0;
    rst = 1'b1;
    #2 rst = 1'b0;
    req_valid = 4'b0001;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_conv_rst", 32'(conv_rst), 32'd1);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_outputs", 32'({rsp_valid, rsp_error, rsp_clamp, busy}), 32'd0);
    chk("rst_bcd_numero", {rsp_bcd, conv_numero}, 32'd0);
    req_valid = '0;
    rst = 1'b1;
    @(posedge clk); #1;

    // all four requesting with values held: order 0,1,2,3
    req_data = {16'd4, 16'd3, 16'd2, 16'd1};
    req_valid = 4'b1111;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("rr_ready", 32'(req_ready), 32'(1 << k));
      @(posedge clk); #1;
      req_valid[k] = 1'b0;
      wait_rsp(n);
      chk("rr_valid", 32'(rsp_valid), 32'(1 << k));
      chk("rr_bcd", 32'(rsp_bcd), 32'(k + 1));
      chk("rr_latency", 32'(n), 32'd6);
    end
    // pointer wrapped: 0 beats 3, then 3 follows
    req_data = {16'd7, 16'd0, 16'd0, 16'd5};
    req_valid = 4'b1001;
    #1;
    chk("wrap_ready0", 32'(req_ready), 32'b0001);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    wait_rsp(n);
    chk("wrap_valid0", 32'(rsp_valid), 32'b0001);
    chk("wrap_bcd0", 32'(rsp_bcd), 32'h0005);
    chk("wrap_ready3", 32'(req_ready), 32'b1000);
    @(posedge clk); #1;
    req_valid[3] = 1'b0;
    wait_rsp(n);
    chk("wrap_valid3", 32'(rsp_valid), 32'b1000);
    chk("wrap_bcd3", 32'(rsp_bcd), 32'h0007);

    run_one(0, 16'd1234, 16'h1234, 12, 1'b0, 1'b0);
    run_one(0, 16'd0,    16'h0000, 6,  1'b0, 1'b0);
    run_one(0, 16'd9999, 16'h9999, 33, 1'b0, 1'b0);

    stall = 1'b1;
    run_one(2, 16'd42, 16'h0000, 128, 1'b1, 1'b0);
    stall = 1'b0;
    run_one(1, 16'd56, 16'h0056, 11, 1'b0, 1'b0);

    // reset during RUN after granting requester 2 (pointer would be 3)
    req_data[47:32] = 16'd1234;
    req_valid = 4'b0100;
    @(posedge clk); #1;
    req_valid = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    req_valid = 4'b0100;
    #1;
    chk("mid_conv_rst", 32'(conv_rst), 32'd1);
    chk("mid_ready", 32'(req_ready), 32'd0);
    chk("mid_outputs", 32'({rsp_valid, rsp_error, rsp_clamp, busy}), 32'd0);
    chk("mid_bcd_numero", {rsp_bcd, conv_numero}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    req_valid = '0;
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (rsp_valid != 4'b0) seen++;
    end
    chk("mid_no_rsp", 32'(seen), 32'd0);
    req_data = {16'd9, 16'd0, 16'd0, 16'd8};
    req_valid = 4'b1001;
    #1;
    chk("ptr_reset_ready", 32'(req_ready), 32'b0001);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    wait_rsp(n);
    chk("ptr_reset_bcd", 32'(rsp_bcd), 32'h0008);
    @(posedge clk); #1;
    req_valid[3] = 1'b0;
    wait_rsp(n);
    chk("ptr_reset_bcd3", 32'(rsp_bcd), 32'h0009);

`ifdef BCD_CLAMP_EN
    run_one(1, 16'd12345, 16'h9999, 33, 1'b0, 1'b1);
`else
    run_one(1, 16'd12345, 16'hC345, 25, 1'b0, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
